// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared types and constants for the hex/decimal score display:
//               FSM state encoding, blank segment pattern and the 16-entry
//               active-low seven-segment code table ({dp,g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index is the digit value 0..F; dp (bit 7) is always off.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_encode
// Description : Combinational 4-bit digit to active-low seven-segment encoder
//               with a blank override.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Table lookup, forced to all-off when the digit is blanked
  always_comb begin
    o_seg = SEG_CODES[i_digit];
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_score_display.sv
`default_nettype none
// ============================================================================
// Module      : hex_score_display
// Description : Converts a 16-bit value to hex (4 digits) or decimal
//               (5 digits, sequential double-dabble) and drives six
//               active-low seven-segment displays with optional
//               leading-zero blanking. Displays update only in LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_score_display
  import hex_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        dec_mode,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic        busy,
  output logic        done
);

  state_t           r_state;
  logic [15:0]      r_bin;
  logic [19:0]      r_bcd;
  logic [3:0]       r_cnt;
  logic [15:0]      r_last_value;
  logic             r_last_mode;
  logic             r_snap_valid;
  logic             r_busy;
  logic             r_done;
  logic [5:0][7:0]  r_hex;

  logic [19:0]      w_bcd_adj;
  logic [35:0]      w_shift;
  logic [19:0]      w_digits_src;
  logic [5:0][3:0]  w_digit;
  logic [5:0]       w_used;
  logic [5:0]       w_lz;
  logic [5:0]       w_blank;
  logic [5:0][7:0]  w_seg;
  logic             w_start;

  // Add-3 correction on every BCD nibble that is 5 or more
  generate
    for (genvar k = 0; k < 5; k++) begin : g_dd_adj
      assign w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ?
                                   (r_bcd[4*k +: 4] + 4'd3) : r_bcd[4*k +: 4];
    end
  endgenerate

  assign w_shift = {w_bcd_adj, r_bin} << 1;

  // A new conversion is needed after reset or when the input differs from
  // the last snapshot that was displayed.
  assign w_start = !r_snap_valid || (value != r_last_value) ||
                   (dec_mode != r_last_mode);

  // Digit sources: BCD result in decimal mode, raw nibbles in hex mode.
  // In hex mode the upper nibble is zero, so digit 4 never affects blanking.
  assign w_digits_src = r_last_mode ? r_bcd : {4'h0, r_last_value};
  assign w_used       = {1'b0, r_last_mode, 4'b1111};

  // Per-digit value, leading-zero chain, blank decision and encoder
  generate
    for (genvar i = 0; i < 6; i++) begin : g_digit
      if (i == 5) begin : g_top
        assign w_digit[i] = 4'h0;
        assign w_lz[i]    = 1'b1;
      end else begin : g_low
        assign w_digit[i] = w_digits_src[4*i +: 4];
        assign w_lz[i]    = w_lz[i+1] && (w_digit[i] == 4'h0);
      end

      if (i == 0) begin : g_lsd
        assign w_blank[i] = 1'b0;
      end else begin : g_msd
        assign w_blank[i] = !w_used[i] || (BLANK_LEADING && w_lz[i]);
      end

      seg7_encode u_seg7_encode (
        .i_digit (w_digit[i]),
        .i_blank (w_blank[i]),
        .o_seg   (w_seg[i])
      );
    end
  endgenerate

  // Control FSM with double-dabble datapath and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_last_value <= '0;
      r_last_mode  <= 1'b0;
      r_snap_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hex        <= {6{SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_bin        <= value;
            r_last_value <= value;
            r_last_mode  <= dec_mode;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= CONVERT;
          end
        end
        CONVERT: begin
          r_bcd <= w_shift[35:16];
          r_bin <= w_shift[15:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_hex        <= w_seg;
          r_snap_valid <= 1'b1;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_score_display
// Description : Scoreboard bench for hex_score_display. Two instances (with
//               and without leading-zero blanking) share stimulus; expected
//               segment patterns come from an arithmetic digit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_score_display;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        dec_mode;

  logic [7:0]  a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
  logic [7:0]  b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
  logic        a_busy, a_done, b_busy, b_done;

  int vectors;
  int miscompares;

  logic [7:0] segtab [16];
  logic [95:0] exp_q [$];   // {expected with blanking, expected without}

  hex_score_display #(.BLANK_LEADING(1'b1)) dut_bl (
    .clk(clk), .reset(reset), .value(value), .dec_mode(dec_mode),
    .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3),
    .hex4(a_hex4), .hex5(a_hex5), .busy(a_busy), .done(a_done)
  );

  hex_score_display #(.BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .value(value), .dec_mode(dec_mode),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3),
    .hex4(b_hex4), .hex5(b_hex5), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [47:0] a_hex();
    return {a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0};
  endfunction

  function automatic logic [47:0] b_hex();
    return {b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};
  endfunction

  // Reference: split the number into base-10/16 digits arithmetically,
  // light digits up to the most significant non-zero one (digit 0 always).
  function automatic logic [47:0] model(input int v, input bit dec, input bit bl);
    int base = dec ? 10 : 16;
    int ndig = dec ? 5 : 4;
    int digs [6];
    int t = v;
    int sig = 1;
    logic [47:0] res;
    for (int i = 0; i < 6; i++) begin
      digs[i] = t % base;
      t = t / base;
    end
    for (int i = 0; i < ndig; i++) begin
      if (digs[i] != 0) sig = i + 1;
    end
    for (int i = 0; i < 6; i++) begin
      res[i*8 +: 8] = 8'hFF;
      if (i < ndig && (!bl || i < sig)) res[i*8 +: 8] = segtab[digs[i]];
    end
    return res;
  endfunction

  task automatic check48(input string name, input logic [47:0] act, input logic [47:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] v, input bit dec);
    exp_q.push_back({model(int'(v), dec, 1'b1), model(int'(v), dec, 1'b0)});
  endtask

  task automatic apply(input logic [15:0] v, input bit dec);
    @(negedge clk);
    value    = v;
    dec_mode = dec;
    push_exp(v, dec);
  endtask

  // Waits (bounded) for a done pulse; n = negedges elapsed including that one
  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (a_done) return;
    end
    miscompares++;
    $display("FAIL timeout: no done within %0d cycles, expected done", n);
  endtask

  // Monitor: pops on each done, checks busy length, single-cycle done and
  // that the displays hold steady between updates.
  initial begin : monitor
    logic [47:0] held_a, held_b;
    logic [95:0] e;
    int busy_cnt;
    bit prev_done;
    held_a = {6{8'hFF}};
    held_b = {6{8'hFF}};
    busy_cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_a = {6{8'hFF}};
        held_b = {6{8'hFF}};
        busy_cnt = 0;
        prev_done = 1'b0;
      end else begin
        if (a_done) begin
          check1("done_pair", b_done, 1'b1);
          check1("busy_low_at_done", a_busy, 1'b0);
          vectors++;
          if (busy_cnt != 17) begin
            miscompares++;
            $display("FAIL busy_len: got %0d cycles expected 17", busy_cnt);
          end
          vectors++;
          if (prev_done) begin
            miscompares++;
            $display("FAIL done_width: got 2+ cycles expected 1");
          end
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            e = exp_q.pop_front();
            check48("display_bl", a_hex(), e[95:48]);
            check48("display_nb", b_hex(), e[47:0]);
            held_a = e[95:48];
            held_b = e[47:0];
          end
        end else begin
          check48("hold_bl", a_hex(), held_a);
          check48("hold_nb", b_hex(), held_b);
        end
        prev_done = a_done;
        busy_cnt  = a_busy ? busy_cnt + 1 : 0;
      end
    end
  end

  initial begin : driver
    int n;
    logic [15:0] v;
    bit m;
    logic [15:0] last_v;
    bit last_m;
    vectors = 0;
    miscompares = 0;
    segtab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reset state
    reset    = 1'b1;
    value    = 16'h1234;
    dec_mode = 1'b0;
    #5;
    check48("reset_hex", a_hex(), {6{8'hFF}});
    check1("reset_busy", a_busy, 1'b0);
    check1("reset_done", a_done, 1'b0);
    repeat (2) @(negedge clk);
    push_exp(16'h1234, 1'b0);
    reset = 1'b0;
    wait_done(n);
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL first_latency: got %0d expected 18", n);
    end

    // Directed patterns
    apply(16'd65535, 1'b1); wait_done(n);
    apply(16'd7,     1'b1); wait_done(n);
    apply(16'd0,     1'b1); wait_done(n);
    apply(16'd0,     1'b0); wait_done(n);
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL latency: got %0d expected 18", n);
    end

    // Input changes during a conversion: 100 is captured, 300 wins after
    apply(16'd100, 1'b1);
    @(negedge clk); value = 16'd200;
    @(negedge clk); value = 16'd300;
    push_exp(16'd300, 1'b1);
    wait_done(n);
    wait_done(n);
    last_v = 16'd300;
    last_m = 1'b1;

    // Randomized transactions
    for (int k = 0; k < 30; k++) begin
      v = 16'($urandom);
      m = 1'($urandom);
      case ($urandom_range(0, 3))
        0: v = 16'($urandom_range(0, 15));
        1: v = 16'($urandom_range(0, 999));
        default: ;
      endcase
      if (v == last_v && m == last_m) m = ~m;
      apply(v, m);
      wait_done(n);
      last_v = v;
      last_m = m;
    end

    // Reset during iteration 8: immediate blanking and restart after release
    apply(16'hBEEF, 1'b1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check48("abort_hex", a_hex(), {6{8'hFF}});
    check48("abort_hex_nb", b_hex(), {6{8'hFF}});
    check1("abort_busy", a_busy, 1'b0);
    @(negedge clk);
    push_exp(16'hBEEF, 1'b1);
    reset = 1'b0;
    wait_done(n);
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL restart_latency: got %0d expected 18", n);
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
